// File: rtl/bcd_to_binary.sv
// rtl/bcd_to_binary.sv - iterative BCD-to-binary converter (reverse double-dabble)
module bcd_to_binary #(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BIN_W-1:0]      bin_out,
    output logic                  err,
    output logic                  busy
);

    localparam int BCD_W  = 4 * DIGITS;
    localparam int WORK_W = BCD_W + BIN_W;
    localparam int CNT_W  = $clog2(BIN_W + 1);

    localparam longint unsigned MAX_DEC   = (64'd10 ** DIGITS) - 64'd1;
    localparam longint unsigned BIN_RANGE = 64'd1 << BIN_W;

    // The largest legal decimal operand must fit in the binary result.
    generate
        if (BIN_RANGE <= MAX_DEC) begin : g_bad_params
            $error("bcd_to_binary: BIN_W too small for DIGITS");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [WORK_W-1:0]   r_work;
    logic [CNT_W-1:0]    r_cnt;
    logic [BIN_W-1:0]    r_bin;
    logic                r_err;
    logic                w_bad;
    logic                w_last;
    logic [WORK_W-1:0]   w_shifted;
    logic [WORK_W-1:0]   w_next_work;

    // Flag any nibble of the operand that is not a decimal digit.
    always_comb begin
        w_bad = 1'b0;
        for (int d = 0; d < DIGITS; d++) begin
            if (bcd_in[4*d +: 4] > 4'd9) begin
                w_bad = 1'b1;
            end
        end
    end

    // One iteration: shift right, then pull 3 out of every BCD digit that reached 8+.
    always_comb begin
        w_shifted   = r_work >> 1;
        w_next_work = w_shifted;
        for (int d = 0; d < DIGITS; d++) begin
            if (w_shifted[BIN_W + 4*d +: 4] >= 4'd8) begin
                w_next_work[BIN_W + 4*d +: 4] = w_shifted[BIN_W + 4*d +: 4] - 4'd3;
            end
        end
    end

    assign w_last = (r_cnt == CNT_W'(1));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_next_state = w_bad ? DONE : CONVERT;
                end
            end
            CONVERT: begin
                if (w_last) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Work register, iteration counter and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_work <= '0;
            r_cnt  <= '0;
            r_bin  <= '0;
            r_err  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        if (w_bad) begin
                            r_bin <= '0;
                            r_err <= 1'b1;
                        end else begin
                            r_work <= {bcd_in, {BIN_W{1'b0}}};
                            r_cnt  <= CNT_W'(BIN_W);
                        end
                    end
                end
                CONVERT: begin
                    r_work <= w_next_work;
                    r_cnt  <= r_cnt - CNT_W'(1);
                    if (w_last) begin
                        r_bin <= w_next_work[BIN_W-1:0];
                        r_err <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign busy      = (r_state == CONVERT);
    assign out_valid = (r_state == DONE);
    assign bin_out   = r_bin;
    assign err       = r_err;

endmodule

// File: tb/tb_bcd_to_binary.sv
// tb/tb_bcd_to_binary.sv - directed self-checking bench for bcd_to_binary
module tb_bcd_to_binary;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] bcd_in;
    logic        out_valid;
    logic        out_ready;
    logic [9:0]  bin_out;
    logic        err;
    logic        busy;

    int checks = 0;
    int errors = 0;

    bcd_to_binary #(.DIGITS(3), .BIN_W(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bcd_in    (bcd_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bin_out   (bin_out),
        .err       (err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_conv(input logic [11:0] b, input int exp_bin, input bit exp_err,
                           input int exp_lat, input string tag);
        int n;
        int bc;
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        bcd_in   = b;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        n  = 0;
        bc = 0;
        while (!out_valid && n < 50) begin
            if (busy) bc++;
            step();
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'(exp_lat));
        check({tag, "_busy_cycles"}, 32'(bc), 32'(exp_lat));
        check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_bin_out"}, 32'(bin_out), 32'(exp_bin));
        check({tag, "_err"}, 32'(err), 32'(exp_err));
        if (!exp_err) begin
            check({tag, "_bcd_residue"}, 32'(dut.r_work[21:10]), 32'd0);
        end
        out_ready = 1'b1;
        step();
        check({tag, "_handoff_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_handoff_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int n;
        logic [11:0] b;

        rst       = 1'b1;
        in_valid  = 1'b0;
        bcd_in    = '0;
        out_ready = 1'b1;
        step();
        step();
        rst = 1'b0;

        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_bin_out", 32'(bin_out), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        do_conv(12'h255, 255, 1'b0, 10, "c255");
        do_conv(12'h999, 999, 1'b0, 10, "c999");
        do_conv(12'h000, 0, 1'b0, 10, "c000");
        do_conv(12'h1A3, 0, 1'b1, 0, "e1A3");
        do_conv(12'hF00, 0, 1'b1, 0, "eF00");

        // Backpressure with stray operands offered while busy and while holding a result.
        out_ready = 1'b0;
        bcd_in    = 12'h042;
        in_valid  = 1'b1;
        step();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 50) begin
            if (n == 3) begin
                in_valid = 1'b1;
                bcd_in   = 12'h777;
            end else begin
                in_valid = 1'b0;
            end
            step();
            n++;
        end
        in_valid = 1'b0;
        check("bp_latency", 32'(n), 32'd10);
        check("bp_bin_out", 32'(bin_out), 32'd42);
        for (int i = 0; i < 20; i++) begin
            in_valid = (i == 5);
            bcd_in   = 12'h777;
            step();
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_hold_bin", 32'(bin_out), 32'd42);
            check("bp_hold_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        check("bp_release_valid", 32'(out_valid), 32'd0);
        check("bp_release_ready", 32'(in_ready), 32'd1);
        step();
        check("bp_no_ghost_busy", 32'(busy), 32'd0);
        check("bp_no_ghost_valid", 32'(out_valid), 32'd0);

        // Reset in the middle of a conversion, with an operand offered alongside it.
        bcd_in   = 12'h500;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        step();
        rst      = 1'b1;
        in_valid = 1'b1;
        bcd_in   = 12'h321;
        step();
        rst      = 1'b0;
        in_valid = 1'b0;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_bin_out", 32'(bin_out), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_busy", 32'(busy), 32'd0);
        do_conv(12'h123, 123, 1'b0, 10, "after_rst");

        // Back-to-back with in_valid held high.
        bcd_in   = 12'h010;
        in_valid = 1'b1;
        step();
        bcd_in = 12'h020;
        n = 0;
        while (!out_valid && n < 50) begin
            step();
            n++;
        end
        check("b2b_lat1", 32'(n), 32'd10);
        check("b2b_bin1", 32'(bin_out), 32'd10);
        step();
        check("b2b_handoff_valid", 32'(out_valid), 32'd0);
        check("b2b_handoff_ready", 32'(in_ready), 32'd1);
        step();
        check("b2b_second_accept", 32'(busy), 32'd1);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 50) begin
            step();
            n++;
        end
        check("b2b_lat2", 32'(n), 32'd10);
        check("b2b_bin2", 32'(bin_out), 32'd20);
        step();

        // Exhaustive sweep of every legal operand.
        for (int v = 0; v < 1000; v++) begin
            b = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
            do_conv(b, v, 1'b0, 10, "sweep");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
